mc_ctrl: RTL

- Multi-cycle control FSM that sequences the execute datapath (ALU, zero flag, branch/PC-select logic).
- Drives one shared ALU and one shared instruction/data memory port through FETCH / DECODE / EXEC / MEM / WB steps; one instruction in flight at a time.
- Sits beside the datapath: takes op/func from the externally held instruction register plus the ALU zero flag and memory ready, and returns all mux selects, write strobes and the memory request.

---
 rtl/mc_ctrl.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for a shared-ALU, shared-memory core.
// Optional build macro MC_ILLEGAL_TRAP_EN traps unsupported opcodes/funcs.
module mc_ctrl #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        op,
  input  logic [5:0]        func,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic              iord,
  output logic              ir_write,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic              target_write,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        alu_op,
  output logic              reg_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              retire,
  output logic              bus_err,
  output logic              illegal,
  output logic [PERF_W-1:0] instr_cnt
);

  localparam int WW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WW-1:0] WLAST = WW'(MEM_WAIT_MAX - 1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_ALU,
    S_WB_MEM,
    S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [PERF_W-1:0] cnt_q, cnt_d;
  logic              berr_q, berr_d;
  logic              ill_q, ill_d;

  logic mem_req_c, ir_write_c, pc_write_c;
  logic target_write_c, reg_write_c, retire_c;
  logic supported, func_ok, timeout;

  assign supported = (op == OP_R) || (op == OP_LW) ||
                     (op == OP_SW) || (op == OP_BEQ) ||
                     (op == OP_ADDI) || (op == OP_J);

  assign func_ok = (func == 6'b100000) || (func == 6'b100010) ||
                   (func == 6'b100100) || (func == 6'b100101) ||
                   (func == 6'b101010);

  // A wait expires when the last allowed cycle passes without ready.
  assign timeout = (wait_q == WLAST) && !mem_ready;

  // State, wait counter, perf counter and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
      berr_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
      ill_q   <= ill_d;
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    state_d        = state_q;
    berr_d         = berr_q;
    ill_d          = ill_q;
    mem_req_c      = 1'b0;
    mem_we         = 1'b0;
    iord           = 1'b0;
    ir_write_c     = 1'b0;
    pc_write_c     = 1'b0;
    pc_src         = 2'd0;
    target_write_c = 1'b0;
    alu_src_a      = 1'b0;
    alu_src_b      = 2'd0;
    alu_op         = 2'd0;
    reg_write_c    = 1'b0;
    reg_dst        = 1'b0;
    mem_to_reg     = 1'b0;
    retire_c       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (timeout) begin
          berr_d  = 1'b1;
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        alu_src_b      = 2'd3;
        target_write_c = 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
        if (!supported || (op == OP_R && !func_ok)) begin
          ill_d   = 1'b1;
          state_d = S_HALT;
        end else if (op == OP_J) begin
          pc_write_c = 1'b1;
          pc_src     = 2'd2;
          retire_c   = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
`else
        if (op == OP_J) begin
          pc_write_c = 1'b1;
          pc_src     = 2'd2;
          retire_c   = 1'b1;
          state_d    = S_FETCH;
        end else if (supported) begin
          state_d = S_EXEC;
        end else begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
`endif
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        unique case (1'b1)
          (op == OP_R): begin
            alu_op  = 2'd2;
            state_d = S_WB_ALU;
          end
          (op == OP_LW): begin
            alu_src_b = 2'd2;
            state_d   = S_MEM_RD;
          end
          (op == OP_SW): begin
            alu_src_b = 2'd2;
            state_d   = S_MEM_WR;
          end
          (op == OP_ADDI): begin
            alu_src_b = 2'd2;
            state_d   = S_WB_ALU;
          end
          (op == OP_BEQ): begin
            alu_op     = 2'd1;
            pc_write_c = zero;
            pc_src     = 2'd1;
            retire_c   = 1'b1;
            state_d    = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM_RD: begin
        mem_req_c = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          state_d = S_WB_MEM;
        end else if (timeout) begin
          berr_d  = 1'b1;
          state_d = S_HALT;
        end
      end
      S_MEM_WR: begin
        mem_req_c = 1'b1;
        mem_we    = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (timeout) begin
          berr_d  = 1'b1;
          state_d = S_HALT;
        end
      end
      S_WB_ALU: begin
        reg_write_c = 1'b1;
        reg_dst     = (op == OP_R);
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
    endcase
  end

  // Wait counter restarts per access and counts unanswered requests.
  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) &&
        ((state_d == S_FETCH) || (state_d == S_MEM_RD) ||
         (state_d == S_MEM_WR))) begin
      wait_d = '0;
    end else if (mem_ready) begin
      wait_d = '0;
    end else if (mem_req_c) begin
      wait_d = wait_q + WW'(1);
    end
  end

  // Retired-instruction counter wraps naturally.
  always_comb begin
    cnt_d = cnt_q + (retire_c ? PERF_W'(1) : '0);
  end

  assign mem_req      = mem_req_c      & ~rst;
  assign ir_write     = ir_write_c     & ~rst;
  assign pc_write     = pc_write_c     & ~rst;
  assign target_write = target_write_c & ~rst;
  assign reg_write    = reg_write_c    & ~rst;
  assign retire       = retire_c       & ~rst;
  assign bus_err      = berr_q;
  assign instr_cnt    = cnt_q;

`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal = ill_q;
`else
  logic unused_trap;
  assign unused_trap = ill_q ^ func_ok;
  assign illegal     = 1'b0;
`endif

endmodule
